// File: rtl/biriscv_longop_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// biriscv_longop_ctrl_pkg
//   Shared definitions for the long-latency operation controller: the
//   per-channel state encoding, the channel-count ceiling and the
//   register/data widths used by the controller and its arbiter.
// ---------------------------------------------------------------------------
package biriscv_longop_ctrl_pkg;

  // Upper bound on NUM_UNITS; the one-hot dispatch vector and the
  // arbiter index are sized from the actual parameter, not this value.
  localparam int LONGOP_MAX_UNITS = 8;

  localparam int XLEN = 32;
  localparam int RD_W = 5;

  // Per-channel lifecycle. KILLED marks an op flushed from the pipe whose
  // unit is still running; its eventual completion must be swallowed.
  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_BUSY   = 2'd1,
    CH_KILLED = 2'd2,
    CH_DONE   = 2'd3
  } ch_state_e;

endpackage

// File: rtl/biriscv_rr_arb.sv
// ---------------------------------------------------------------------------
// biriscv_rr_arb
//   N-way round-robin arbiter with a registered priority pointer.
//   Search starts at the pointer; on an accepted grant the pointer moves
//   to the slot after the winner. An offered but unaccepted grant is held
//   on the same requester so downstream sees a stable choice.
//
//   Ports:
//     clk_i        clock
//     rst_i        asynchronous active-high reset
//     req_i        request vector
//     accept_i     current grant was consumed this cycle
//     grant_o      one-hot grant (zero when no request)
//     grant_idx_o  binary index of the granted requester
// ---------------------------------------------------------------------------
module biriscv_rr_arb #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     req_i,
  input  logic             accept_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o
);

  logic [IDX_W-1:0] r_ptr;
  logic             r_locked;
  logic [IDX_W-1:0] r_lock_idx;

  logic             w_found;
  int               w_j;

  // NOTE: every variable assigned in a combinational block gets a default
  // at the top so no path leaves it unassigned and infers a latch.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    w_found     = 1'b0;
    w_j         = 0;
    if (r_locked && req_i[r_lock_idx]) begin
      grant_o[r_lock_idx] = 1'b1;
      grant_idx_o         = r_lock_idx;
    end else begin
      for (int i = 0; i < N; i++) begin
        w_j = int'(r_ptr) + i;
        if (w_j >= N) w_j = w_j - N;
        if (!w_found && req_i[w_j]) begin
          w_found       = 1'b1;
          grant_o[w_j]  = 1'b1;
          grant_idx_o   = IDX_W'(w_j);
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr      <= '0;
      r_locked   <= 1'b0;
      r_lock_idx <= '0;
    end else begin
      if (accept_i && (|grant_o)) begin
        r_ptr <= (grant_idx_o == IDX_W'(N - 1)) ? '0 : grant_idx_o + 1'b1;
      end
      // Lock only while a grant is being offered and not yet taken.
      r_locked   <= (|grant_o) & ~accept_i;
      r_lock_idx <= grant_idx_o;
    end
  end

endmodule

// File: rtl/biriscv_longop_ctrl.sv
// ---------------------------------------------------------------------------
// biriscv_longop_ctrl
//   Tracks ops dispatched to out-of-pipe long-latency units (divider,
//   extended multiplier, ...). One outstanding op per channel; keeps a
//   destination-register scoreboard for hazard/WAW checks, captures unit
//   results and drains them round-robin onto a dedicated writeback port.
//
//   Ports:
//     clk_i, rst_i             clock, async active-high reset
//     issue_valid_i/unit_i/rd_i/pc_i, issue_accept_o   dispatch handshake
//     unit_complete_i, unit_result_i                   per-unit completion
//     flush_i                  kills every outstanding op
//     hzd_ra_i, hzd_rb_i, hzd_o   source-operand hazard query
//     wb_valid_o/rd_o/result_o/pc_o, wb_accept_i       writeback port
//     busy_o                   per-channel not-IDLE
//     err_o                    sticky: completion on a channel not BUSY/KILLED
// ---------------------------------------------------------------------------
module biriscv_longop_ctrl
  import biriscv_longop_ctrl_pkg::*;
#(
  parameter int NUM_UNITS        = 2,
  parameter bit SUPPORT_RD0_DROP = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      issue_valid_i,
  input  logic [NUM_UNITS-1:0]      issue_unit_i,
  input  logic [RD_W-1:0]           issue_rd_i,
  input  logic [XLEN-1:0]           issue_pc_i,
  output logic                      issue_accept_o,
  input  logic [NUM_UNITS-1:0]      unit_complete_i,
  input  logic [XLEN*NUM_UNITS-1:0] unit_result_i,
  input  logic                      flush_i,
  input  logic [RD_W-1:0]           hzd_ra_i,
  input  logic [RD_W-1:0]           hzd_rb_i,
  output logic                      hzd_o,
  output logic                      wb_valid_o,
  output logic [RD_W-1:0]           wb_rd_o,
  output logic [XLEN-1:0]           wb_result_o,
  output logic [XLEN-1:0]           wb_pc_o,
  input  logic                      wb_accept_i,
  output logic [NUM_UNITS-1:0]      busy_o,
  output logic                      err_o
);

  localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  ch_state_e          r_state  [NUM_UNITS];
  ch_state_e          w_state_nxt [NUM_UNITS];
  logic [RD_W-1:0]    r_rd     [NUM_UNITS];
  logic [XLEN-1:0]    r_pc     [NUM_UNITS];
  logic [XLEN-1:0]    r_result [NUM_UNITS];
  logic               r_err;

  logic [NUM_UNITS-1:0] w_idle_vec;
  logic [NUM_UNITS-1:0] w_done_vec;
  logic [NUM_UNITS-1:0] w_issue_hit;
  logic [NUM_UNITS-1:0] w_capture;
  logic [NUM_UNITS-1:0] w_arb_req;
  logic [NUM_UNITS-1:0] w_grant;
  logic [IDX_W-1:0]     w_grant_idx;
  logic                 w_waw;
  logic                 w_wb_fire;
  logic                 w_err_set;

  // -------------------------------------------------------------------------
  // Scoreboard compares: only BUSY/DONE channels own their rd. KILLED
  // results never reach the register file, so they neither hazard nor
  // block a new writer of the same register.
  // -------------------------------------------------------------------------
  always_comb begin
    w_waw      = 1'b0;
    hzd_o      = 1'b0;
    w_idle_vec = '0;
    w_done_vec = '0;
    busy_o     = '0;
    for (int n = 0; n < NUM_UNITS; n++) begin
      w_idle_vec[n] = (r_state[n] == CH_IDLE);
      w_done_vec[n] = (r_state[n] == CH_DONE);
      busy_o[n]     = (r_state[n] != CH_IDLE);
      if ((r_state[n] == CH_BUSY || r_state[n] == CH_DONE) && r_rd[n] != '0) begin
        if (r_rd[n] == issue_rd_i) w_waw = 1'b1;
        if (r_rd[n] == hzd_ra_i || r_rd[n] == hzd_rb_i) hzd_o = 1'b1;
      end
    end
  end

  // rd=0 is excluded inside the compare above, so x0 never blocks issue.
  assign issue_accept_o = issue_valid_i & ~rst_i & ~flush_i & ~w_waw
                        & $onehot(issue_unit_i)
                        & (|(issue_unit_i & w_idle_vec));

  // -------------------------------------------------------------------------
  // Writeback arbitration. Flush masks requests so a dying result is never
  // offered, and that also makes flush win over a same-cycle accept.
  // -------------------------------------------------------------------------
  assign w_arb_req = w_done_vec & {NUM_UNITS{~flush_i}};

  biriscv_rr_arb #(
    .N     (NUM_UNITS),
    .IDX_W (IDX_W)
  ) u_arb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (w_arb_req),
    .accept_i    (wb_accept_i),
    .grant_o     (w_grant),
    .grant_idx_o (w_grant_idx)
  );

  assign wb_valid_o  = |w_grant;
  assign w_wb_fire   = wb_valid_o & wb_accept_i;
  assign wb_rd_o     = wb_valid_o ? r_rd[w_grant_idx]     : '0;
  assign wb_result_o = wb_valid_o ? r_result[w_grant_idx] : '0;
  assign wb_pc_o     = wb_valid_o ? r_pc[w_grant_idx]     : '0;

  // -------------------------------------------------------------------------
  // Per-channel next state
  // -------------------------------------------------------------------------
  always_comb begin
    w_err_set   = 1'b0;
    w_issue_hit = '0;
    w_capture   = '0;
    for (int n = 0; n < NUM_UNITS; n++) begin
      w_state_nxt[n] = r_state[n];
      w_issue_hit[n] = issue_accept_o & issue_unit_i[n];
      case (r_state[n])
        CH_IDLE: begin
          if (unit_complete_i[n]) w_err_set = 1'b1;
          if (w_issue_hit[n])     w_state_nxt[n] = CH_BUSY;
        end
        CH_BUSY: begin
          if (flush_i) begin
            // A completion landing with the flush has nothing left to kill.
            w_state_nxt[n] = unit_complete_i[n] ? CH_IDLE : CH_KILLED;
          end else if (unit_complete_i[n]) begin
            if (SUPPORT_RD0_DROP && r_rd[n] == '0) begin
              w_state_nxt[n] = CH_IDLE;
            end else begin
              w_state_nxt[n] = CH_DONE;
              w_capture[n]   = 1'b1;
            end
          end
        end
        CH_KILLED: begin
          if (unit_complete_i[n]) w_state_nxt[n] = CH_IDLE;
        end
        CH_DONE: begin
          if (unit_complete_i[n]) w_err_set = 1'b1;
          if (flush_i || (w_wb_fire && w_grant[n])) w_state_nxt[n] = CH_IDLE;
        end
        default: w_state_nxt[n] = CH_IDLE;
      endcase
    end
  end

  // NOTE: the per-channel payload arrays are reset along with the state;
  // they are a handful of flops per channel, and a defined value keeps the
  // writeback mux outputs clean straight out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int n = 0; n < NUM_UNITS; n++) begin
        r_state[n]  <= CH_IDLE;
        r_rd[n]     <= '0;
        r_pc[n]     <= '0;
        r_result[n] <= '0;
      end
      r_err <= 1'b0;
    end else begin
      for (int n = 0; n < NUM_UNITS; n++) begin
        r_state[n] <= w_state_nxt[n];
        if (w_issue_hit[n]) begin
          r_rd[n] <= issue_rd_i;
          r_pc[n] <= issue_pc_i;
        end
        if (w_capture[n]) r_result[n] <= unit_result_i[XLEN*n +: XLEN];
      end
      r_err <= r_err | w_err_set;
    end
  end

  assign err_o = r_err;

endmodule
